// File: rtl/prog_loader_if.sv
// Boot-loader stream input and memory write bus.
// The loader takes the slave modport; the stream source / memory side takes master.
interface prog_loader_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 11,
  parameter int NUM_TGT = 2
);
  logic [DATA_W-1:0]  s_data;
  logic               s_valid;
  logic               s_ready;
  logic [NUM_TGT-1:0] mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  modport slave (
    input  s_data, s_valid,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output s_data, s_valid,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Framed-stream boot loader: decodes frame headers, writes payload words into
// one of NUM_TGT memories, checks a per-frame XOR checksum, then releases the core.
module prog_loader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 11,
  parameter int NUM_TGT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          core_rst,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam logic [12:0] ADDR_SPAN = 13'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state, state_nxt;
  logic [TGT_W-1:0]    tgt_q, tgt_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [11:0]         cnt_q, cnt_nxt;
  logic [DATA_W-1:0]   csum_q, csum_nxt;
  logic [NUM_TGT-1:0]  we_q, we_nxt;
  logic [ADDR_W-1:0]   maddr_q, maddr_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [1:0]          code_q, code_nxt;

  logic                accept;
  logic [7:0]          hdr_tgt;
  logic [11:0]         hdr_n;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [12:0]         hdr_end;
  logic [NUM_TGT-1:0]  tgt_hot;

  assign bus.s_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CKSUM);
  assign accept      = bus.s_valid && bus.s_ready;

  assign hdr_tgt  = bus.s_data[31:24];
  assign hdr_n    = bus.s_data[23:12];
  assign hdr_addr = bus.s_data[ADDR_W-1:0];
  // 13-bit sum so start+N can exceed 2^ADDR_W without wrapping
  assign hdr_end  = 13'(hdr_addr) + 13'(hdr_n);

  always_comb begin
    tgt_hot = '0;
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      tgt_hot[i] = (tgt_q == TGT_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_HDR;
      tgt_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      we_q    <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      code_q  <= '0;
    end else begin
      state   <= state_nxt;
      tgt_q   <= tgt_nxt;
      addr_q  <= addr_nxt;
      cnt_q   <= cnt_nxt;
      csum_q  <= csum_nxt;
      we_q    <= we_nxt;
      maddr_q <= maddr_nxt;
      wdata_q <= wdata_nxt;
      code_q  <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt_q;
    addr_nxt  = addr_q;
    cnt_nxt   = cnt_q;
    csum_nxt  = csum_q;
    we_nxt    = '0;
    maddr_nxt = maddr_q;
    wdata_nxt = wdata_q;
    code_nxt  = code_q;

    unique case (state)
      S_HDR: begin
        if (accept) begin
          if (hdr_n == 12'd0) begin
            state_nxt = S_DONE;
          end else if (int'(hdr_tgt) >= NUM_TGT) begin
            state_nxt = S_ERR;
            code_nxt  = 2'd1;
          end else if (hdr_end > ADDR_SPAN) begin
            state_nxt = S_ERR;
            code_nxt  = 2'd2;
          end else begin
            tgt_nxt   = TGT_W'(hdr_tgt);
            addr_nxt  = hdr_addr;
            cnt_nxt   = hdr_n;
            csum_nxt  = '0;
            state_nxt = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          we_nxt    = tgt_hot;
          maddr_nxt = addr_q;
          wdata_nxt = bus.s_data;
          addr_nxt  = addr_q + 1'b1;
          csum_nxt  = csum_q ^ bus.s_data;
          cnt_nxt   = cnt_q - 12'd1;
          if (cnt_q == 12'd1) begin
            state_nxt = S_CKSUM;
          end
        end
      end

      S_CKSUM: begin
        if (accept) begin
          if (bus.s_data == csum_q) begin
            state_nxt = S_HDR;
          end else begin
            state_nxt = S_ERR;
            code_nxt  = 2'd3;
          end
        end
      end

      S_DONE, S_ERR: begin
        if (start) begin
          state_nxt = S_HDR;
          code_nxt  = 2'd0;
        end
      end

      default: state_nxt = S_HDR;
    endcase
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_rst      = (state != S_DONE);
  assign done          = (state == S_DONE);
  assign err           = (state == S_ERR);
  assign err_code      = code_q;

endmodule
